// File: rtl/phase_sequencer.sv
// Purpose: six-phase intersection timing controller with sensor-driven table select and ped walk extension.
// Latency: one LOAD cycle per phase, then T*TICK_DIV RUN cycles; CG/table/remaining register on the LOAD edge.
// Backpressure: none; sensors are sampled only in LOAD, presses are latched until their group's green phase.
module phase_sequencer #(
   parameter int TICK_DIV = 48000000,
   parameter int DEF_TIME = 17,
   parameter int PED_EXT  = 5
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       snn_i,
   input  logic       sns_i,
   input  logic       sth_i,
   input  logic       pnn_i,
   input  logic       pns_i,
   input  logic       pth_i,
   input  logic       cfg_we_i,
   input  logic [1:0] cfg_table_i,
   input  logic [2:0] cfg_phase_i,
   input  logic [7:0] cfg_time_i,
   output logic [2:0] phase_o,
   output logic [1:0] table_o,
   output logic [7:0] remaining_o,
   output logic       phase_start_o,
   output logic [2:0] ped_ack_o,
   output logic       cs1_o,
   output logic       cs2_o,
   output logic       cs3_o,
   output logic       cg1_o,
   output logic       cg2_o,
   output logic       cg3_o
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   typedef enum logic {ST_LOAD, ST_RUN} state_t;

   state_t        state_q, state_d;
   logic [2:0]    phase_q, phase_d;
   logic [1:0]    table_q, table_d;
   logic [7:0]    remaining_q, remaining_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [2:0]    cg_q, cg_d;
   logic [2:0]    req_q, req_d;
   logic [7:0]    time_q [0:3][0:5];

   logic [2:0]    press;
   logic          start_c;
   logic [2:0]    ack_c;
   logic [2:0]    cs_c;
   logic [1:0]    load_tbl;
   logic [7:0]    load_time;
   logic [8:0]    ext_sum;
   logic [1:0]    grp;

   assign press = {pth_i, pns_i, pnn_i};

   // Next-state: LOAD picks the table and duration, serves ped requests; RUN counts ticks down to the phase change.
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      table_d     = table_q;
      remaining_d = remaining_q;
      presc_d     = presc_q;
      cg_d        = cg_q;
      req_d       = req_q | press;
      start_c     = 1'b0;
      ack_c       = 3'b000;
      cs_c        = 3'b000;
      load_tbl    = 2'd0;
      load_time   = 8'd0;
      ext_sum     = 9'd0;
      grp         = 2'd0;
      case (state_q)
         ST_LOAD: begin
            start_c = 1'b1;
            // A single congested approach gets its own table; anything else runs the balanced table A.
            case ({sth_i, sns_i, snn_i})
               3'b100:  load_tbl = 2'd1;
               3'b001:  load_tbl = 2'd2;
               3'b010:  load_tbl = 2'd3;
               default: load_tbl = 2'd0;
            endcase
            load_time = time_q[load_tbl][phase_q];
            if (load_time == 8'd0) begin
               load_time = 8'd1;
            end
            remaining_d = load_time;
            table_d     = load_tbl;
            presc_d     = '0;
            state_d     = ST_RUN;
            cg_d        = 3'b000;
            // Even phases are the green phase of group phase/2; that is where walk requests are served.
            if (!phase_q[0]) begin
               grp  = phase_q[2:1];
               cg_d = 3'b001 << grp;
               if (req_q[grp] | press[grp]) begin
                  ack_c[grp]  = 1'b1;
                  req_d[grp]  = 1'b0;
                  ext_sum     = {1'b0, load_time} + 9'(PED_EXT);
                  remaining_d = ext_sum[8] ? 8'hFF : ext_sum[7:0];
               end
            end
            // Group k's lamps change entering its green, its yellow, and the red that follows.
            case (phase_q)
               3'd0:    cs_c = 3'b101;
               3'd1:    cs_c = 3'b001;
               3'd2:    cs_c = 3'b011;
               3'd3:    cs_c = 3'b010;
               3'd4:    cs_c = 3'b110;
               3'd5:    cs_c = 3'b100;
               default: cs_c = 3'b000;
            endcase
         end
         default: begin
            if (presc_q == PRESC_LAST) begin
               presc_d     = '0;
               remaining_d = remaining_q - 8'd1;
               if (remaining_q == 8'd1) begin
                  phase_d = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
                  state_d = ST_LOAD;
               end
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
      endcase
   end

   // Sequencer state and datapath registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_LOAD;
         phase_q     <= 3'd0;
         table_q     <= 2'd0;
         remaining_q <= 8'd0;
         presc_q     <= '0;
         cg_q        <= 3'b000;
         req_q       <= 3'b000;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         table_q     <= table_d;
         remaining_q <= remaining_d;
         presc_q     <= presc_d;
         cg_q        <= cg_d;
         req_q       <= req_d;
      end
   end

   // Programmable phase-time table; LOAD reads the pre-write value when both hit the same entry.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int t = 0; t < 4; t++) begin
            for (int p = 0; p < 6; p++) begin
               time_q[t][p] <= 8'(DEF_TIME);
            end
         end
      end else if (cfg_we_i && (cfg_phase_i <= 3'd5)) begin
         time_q[cfg_table_i][cfg_phase_i] <= cfg_time_i;
      end
   end

   // Strobes are only meaningful out of reset, since the FSM idles in LOAD while reset is held.
   assign phase_start_o = start_c & ~rst_i;
   assign ped_ack_o     = ack_c & {3{~rst_i}};
   assign cs1_o         = cs_c[0] & ~rst_i;
   assign cs2_o         = cs_c[1] & ~rst_i;
   assign cs3_o         = cs_c[2] & ~rst_i;
   assign cg1_o         = cg_q[0];
   assign cg2_o         = cg_q[1];
   assign cg3_o         = cg_q[2];
   assign phase_o       = phase_q;
   assign table_o       = table_q;
   assign remaining_o   = remaining_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: per-phase expectations from a vector table, compared at each LOAD.
// Latency: expectations are checked one cycle after the LOAD that produced them.
// Backpressure: none; every wait on the DUT is bounded by a cycle budget.
module tb_phase_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       snn = 1'b0, sns = 1'b0, sth = 1'b0;
   logic       pnn = 1'b0, pns = 1'b0, pth = 1'b0;
   logic       cfg_we = 1'b0;
   logic [1:0] cfg_table = 2'd0;
   logic [2:0] cfg_phase = 3'd0;
   logic [7:0] cfg_time = 8'd0;
   logic [2:0] phase_o;
   logic [1:0] table_o;
   logic [7:0] remaining_o;
   logic       phase_start_o;
   logic [2:0] ped_ack_o;
   logic       cs1, cs2, cs3, cg1, cg2, cg3;

   int total = 0;
   int bad   = 0;

   phase_sequencer #(.TICK_DIV(4), .DEF_TIME(17), .PED_EXT(5)) dut (
      .clk_i(clk), .rst_i(rst),
      .snn_i(snn), .sns_i(sns), .sth_i(sth),
      .pnn_i(pnn), .pns_i(pns), .pth_i(pth),
      .cfg_we_i(cfg_we), .cfg_table_i(cfg_table), .cfg_phase_i(cfg_phase), .cfg_time_i(cfg_time),
      .phase_o(phase_o), .table_o(table_o), .remaining_o(remaining_o),
      .phase_start_o(phase_start_o), .ped_ack_o(ped_ack_o),
      .cs1_o(cs1), .cs2_o(cs2), .cs3_o(cs3),
      .cg1_o(cg1), .cg2_o(cg2), .cg3_o(cg3)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] ph;
      logic [1:0] tbl;
      logic [7:0] rem;
      int         dur;   // 0: duration not checked
      logic [2:0] cs;
      logic [2:0] cg;
      logic [2:0] ack;
   } exp_t;

   typedef struct {
      logic [2:0] sens;  // {sth, sns, snn} applied before this LOAD
      exp_t       e;
      logic       wr;    // config write issued after this LOAD
      logic [1:0] wt;
      logic [2:0] wp;
      logic [7:0] wv;
      logic [2:0] press; // {pth, pns, pnn} one-cycle press after this LOAD
   } vec_t;

   exp_t exp_q[$];
   vec_t vecs[$];

   task automatic chk(input string nm, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d at %0t", nm, act, want, $time);
      end
   endtask

   task automatic add(input logic [2:0] s, input logic [2:0] ph, input logic [1:0] tb_,
                      input logic [7:0] rem, input int dur, input logic [2:0] cs,
                      input logic [2:0] cg, input logic [2:0] ack, input logic wr,
                      input logic [1:0] wt, input logic [2:0] wp, input logic [7:0] wv,
                      input logic [2:0] pr);
      vec_t v;
      v.sens = s;   v.e.ph = ph; v.e.tbl = tb_; v.e.rem = rem; v.e.dur = dur;
      v.e.cs = cs;  v.e.cg = cg; v.e.ack = ack;
      v.wr = wr;    v.wt = wt;   v.wp = wp;     v.wv = wv;     v.press = pr;
      vecs.push_back(v);
   endtask

   task automatic push_exp(input logic [2:0] ph, input logic [1:0] tb_, input logic [7:0] rem,
                           input int dur, input logic [2:0] cs, input logic [2:0] cg);
      exp_t e;
      e.ph = ph; e.tbl = tb_; e.rem = rem; e.dur = dur; e.cs = cs; e.cg = cg; e.ack = 3'b000;
      exp_q.push_back(e);
   endtask

   task automatic wait_pop();
      for (int k = 0; k < 3000; k++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      if (exp_q.size() != 0) begin
         chk("load_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
   endtask

   // Monitor: capture strobes in the LOAD cycle, registered outputs one cycle later, then score.
   int         cyc = 0, last_load = 0;
   logic       pend = 1'b0;
   logic [2:0] cap_ph, cap_cs, cap_ack;
   int         cap_dur;
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (pend) begin
         pend = 1'b0;
         if (exp_q.size() == 0) begin
            chk("unexpected_load", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("phase", cap_ph, e.ph);
            chk("cs", cap_cs, e.cs);
            chk("ped_ack", cap_ack, e.ack);
            if (e.dur != 0) chk("duration", cap_dur, e.dur);
            chk("table", table_o, e.tbl);
            chk("remaining", remaining_o, e.rem);
            chk("cg", {cg3, cg2, cg1}, e.cg);
         end
      end
      if (phase_start_o) begin
         cap_ph  = phase_o;
         cap_cs  = {cs3, cs2, cs1};
         cap_ack = ped_ack_o;
         cap_dur = cyc - last_load;
         last_load = cyc;
         pend = 1'b1;
      end
   end

   initial begin
      //   sens    ph  tb  rem  dur   cs      cg      ack     wr  wt  wp  wv   press
      add(3'b000, 0, 0, 17,   0, 3'b101, 3'b001, 3'b000, 0, 0, 0, 0,   3'b000);
      add(3'b000, 1, 0, 17,  69, 3'b001, 3'b000, 3'b000, 0, 0, 0, 0,   3'b000);
      add(3'b000, 2, 0, 17,  69, 3'b011, 3'b010, 3'b000, 0, 0, 0, 0,   3'b000);
      add(3'b000, 3, 0, 17,  69, 3'b010, 3'b000, 3'b000, 0, 0, 0, 0,   3'b000);
      add(3'b000, 4, 0, 17,  69, 3'b110, 3'b100, 3'b000, 0, 0, 0, 0,   3'b000);
      add(3'b000, 5, 0, 17,  69, 3'b100, 3'b000, 3'b000, 0, 0, 0, 0,   3'b000);
      add(3'b000, 0, 0, 17,  69, 3'b101, 3'b001, 3'b000, 1, 0, 1, 3,   3'b000);
      add(3'b000, 1, 0,  3,  69, 3'b001, 3'b000, 3'b000, 1, 0, 2, 0,   3'b000);
      add(3'b000, 2, 0,  1,  13, 3'b011, 3'b010, 3'b000, 1, 1, 1, 10,  3'b000);
      add(3'b000, 3, 0, 17,   5, 3'b010, 3'b000, 3'b000, 1, 0, 6, 2,   3'b000);
      add(3'b000, 4, 0, 17,  69, 3'b110, 3'b100, 3'b000, 0, 0, 0, 0,   3'b000);
      add(3'b000, 5, 0, 17,  69, 3'b100, 3'b000, 3'b000, 0, 0, 0, 0,   3'b000);
      add(3'b000, 0, 0, 17,  69, 3'b101, 3'b001, 3'b000, 0, 0, 0, 0,   3'b000);
      add(3'b100, 1, 1, 10,  69, 3'b001, 3'b000, 3'b000, 0, 0, 0, 0,   3'b100);
      add(3'b111, 2, 0,  1,  41, 3'b011, 3'b010, 3'b000, 0, 0, 0, 0,   3'b000);
      add(3'b000, 3, 0, 17,   5, 3'b010, 3'b000, 3'b000, 0, 0, 0, 0,   3'b000);
      add(3'b000, 4, 0, 22,  69, 3'b110, 3'b100, 3'b100, 0, 0, 0, 0,   3'b000);
      add(3'b000, 5, 0, 17,  89, 3'b100, 3'b000, 3'b000, 0, 0, 0, 0,   3'b000);
      add(3'b000, 0, 0, 17,  69, 3'b101, 3'b001, 3'b000, 1, 0, 0, 253, 3'b000);
      add(3'b000, 1, 0,  3,  69, 3'b001, 3'b000, 3'b000, 0, 0, 0, 0,   3'b001);
      add(3'b001, 2, 2, 17,  13, 3'b011, 3'b010, 3'b000, 0, 0, 0, 0,   3'b000);
      add(3'b010, 3, 3, 17,  69, 3'b010, 3'b000, 3'b000, 0, 0, 0, 0,   3'b000);
      add(3'b000, 4, 0, 17,  69, 3'b110, 3'b100, 3'b000, 1, 0, 4, 2,   3'b000);
      add(3'b000, 5, 0, 17,  69, 3'b100, 3'b000, 3'b000, 0, 0, 0, 0,   3'b000);
      add(3'b000, 0, 0, 255, 69, 3'b101, 3'b001, 3'b001, 0, 0, 0, 0,   3'b000);
      add(3'b000, 1, 0,  3, 1021, 3'b001, 3'b000, 3'b000, 0, 0, 0, 0,  3'b000);
      add(3'b000, 2, 0,  1,  13, 3'b011, 3'b010, 3'b000, 0, 0, 0, 0,   3'b000);
      add(3'b000, 3, 0, 17,   5, 3'b010, 3'b000, 3'b000, 0, 0, 0, 0,   3'b000);

      // Outputs held in reset.
      repeat (3) @(negedge clk);
      chk("rst_phase", phase_o, 0);
      chk("rst_table", table_o, 0);
      chk("rst_remaining", remaining_o, 0);
      chk("rst_phase_start", phase_start_o, 0);
      chk("rst_ped_ack", ped_ack_o, 0);
      chk("rst_cs", {cs3, cs2, cs1}, 0);
      chk("rst_cg", {cg3, cg2, cg1}, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         {sth, sns, snn} = vecs[i].sens;
         exp_q.push_back(vecs[i].e);
         if (i == 0) begin
            @(posedge clk);
            #1 rst = 1'b0;
         end
         wait_pop();
         if (vecs[i].wr) begin
            @(negedge clk);
            cfg_we = 1'b1; cfg_table = vecs[i].wt; cfg_phase = vecs[i].wp; cfg_time = vecs[i].wv;
            @(negedge clk);
            cfg_we = 1'b0;
         end
         if (vecs[i].press != 3'b000) begin
            @(negedge clk);
            {pth, pns, pnn} = vecs[i].press;
            @(negedge clk);
            {pth, pns, pnn} = 3'b000;
         end
      end

      // Asynchronous reset mid phase 3, then programmed times must be back to defaults.
      {sth, sns, snn} = 3'b000;
      for (int k = 0; k < 200; k++) begin
         if (remaining_o == 8'd9) break;
         @(negedge clk);
      end
      chk("wait_remaining9", remaining_o, 9);
      #1 rst = 1'b1;
      #1;
      chk("arst_phase", phase_o, 0);
      chk("arst_table", table_o, 0);
      chk("arst_remaining", remaining_o, 0);
      chk("arst_phase_start", phase_start_o, 0);
      chk("arst_cs", {cs3, cs2, cs1}, 0);
      chk("arst_cg", {cg3, cg2, cg1}, 0);
      repeat (2) @(negedge clk);
      push_exp(3'd0, 2'd0, 8'd17, 0,  3'b101, 3'b001);
      push_exp(3'd1, 2'd0, 8'd17, 69, 3'b001, 3'b000);
      @(posedge clk);
      #1 rst = 1'b0;
      wait_pop();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Timing controller for the three-approach intersection: Norton Norte (group 1), Norton Sur (group 2), Thames (group 3).
- Steps the light controller through six phases, E1..E6 (indices 0..5).
- Selects timing table A..D from the approach sensors at each phase boundary.
- Holds a programmable 4x6 phase-time table and serves latched pedestrian requests by extending the walk phase.
- Drives the CS1..CS3 change strobes and the CG1..CG3 green levels consumed by the lamp drivers.

Parameters:
TICK_DIV, 48000000, CLK cycles per one-second tick (benches use 4)
DEF_TIME, 17, reset value of every phase-time entry, in seconds
PED_EXT, 5, seconds added to a walk phase when a pedestrian request is served

Ports:
CLK  in  1  system clock, 48 MHz
RST  in  1  asynchronous active-high reset
SNN  in  1  Norton Norte congestion sensor, synchronous to CLK
SNS  in  1  Norton Sur congestion sensor
STH  in  1  Thames congestion sensor
PNN  in  1  Norton Norte pedestrian button (pulse or level)
PNS  in  1  Norton Sur pedestrian button
PTH  in  1  Thames pedestrian button
cfg_we  in  1  phase-time write strobe
cfg_table  in  2  table to write: 0=A, 1=B, 2=C, 3=D
cfg_phase  in  3  phase to write, 0..5
cfg_time  in  8  phase duration in seconds
phase  out  3  current phase, 0..5
table  out  2  table in use for the current phase
remaining  out  8  seconds left in the current phase
phase_start  out  1  one-cycle pulse in each LOAD cycle
ped_ack  out  3  one-cycle pulse per group when its request is served
CS1..CS3  out  1 each  one-cycle change strobe for group k
CG1..CG3  out  1 each  level: group k green

Behaviour:
- Reset is asynchronous and active-high (RST). While RST is high:
  - phase=0, table=0, remaining=0.
  - phase_start, ped_ack, CS and CG outputs all 0.
  - Pedestrian latches cleared; prescaler cleared.
  - All 24 time entries set to DEF_TIME.
  - FSM goes to LOAD.
- FSM has two states:
  - LOAD, one cycle: phase_start=1.
  - RUN: lasts until the phase expires.
- LOAD cycle actions:
  - Select table from the sensors sampled this cycle. Priority: STH only -> B; SNN only -> C; SNS only -> D; any other combination -> A.
  - Load remaining = time[table][phase]. A stored value of 0 is loaded as 1.
  - Clear the prescaler.
  - Serve pedestrian requests (see below).
  - Go to RUN.
- RUN state:
  - Prescaler counts 0..TICK_DIV-1 and issues a tick on TICK_DIV-1.
  - remaining decrements on each tick.
  - On the tick that takes remaining from 1 to 0: phase <= (phase==5) ? 0 : phase+1, then go to LOAD.
- Phase duration is exactly 1 + T*TICK_DIV cycles, measured LOAD to LOAD.
- The table and duration stay fixed for the whole phase; sensor changes during RUN are ignored.
- Group mapping: group k is green in phase 2(k-1), yellow in phase 2(k-1)+1, red otherwise.
  - CGk is registered and updates in the LOAD cycle.
  - CSk pulses in the LOAD cycle of phases 2(k-1), 2(k-1)+1 and (2(k-1)+2) mod 6.
  - The first LOAD after reset release pulses CS1 and raises CG1.
- Pedestrian requests:
  - Any high cycle on PNN/PNS/PTH sets the request bit for group 1/2/3.
  - In the LOAD cycle of a group's green phase with its request set: remaining = min(T + PED_EXT, 255); ped_ack[k] pulses; the request clears.
  - A press in that same LOAD cycle counts as served and is not re-latched.
  - Requests for other groups persist until their own green phase.
- Configuration writes:
  - With cfg_we high, time[cfg_table][cfg_phase] <= cfg_time on the next edge.
  - cfg_phase > 5 is ignored.
  - A write to the entry currently running does not alter remaining; it takes effect at the next LOAD of that entry.
  - A write in the same cycle as a LOAD of the same entry: LOAD uses the old value.
- RST asserted mid-RUN aborts the phase immediately; programmed times are lost and revert to DEF_TIME.

Test Plan:
- TICK_DIV=4, sensors 0, release RST -> first LOAD next cycle: phase=0, CS1 pulse, CG1=1. Phase 1 LOAD 69 cycles later; phase returns to 0 after 414 cycles with table=0 throughout.
- Write table A phase 1 = 3 during phase 0 -> phase 1 lasts 13 cycles. Also write cfg_time=0 to phase 2 -> phase 2 lasts 5 cycles.
- STH=1, SNN=SNS=0 at phase 0->1 LOAD with time_B[1]=10 -> table=1, remaining=10, phase 1 lasts 41 cycles. Then all sensors=1 at the next LOAD -> table=0.
- One-cycle PTH pulse in phase 1 -> phase 4 LOAD: remaining=22, ped_ack=3'b100, phase lasts 89 cycles. The next phase 4 (no press) lasts 69.
- Table A phase 0 = 253 plus a PNN request -> remaining=255, not 2.
- RST pulse during phase 3 with remaining=9 -> all outputs 0 without waiting for CLK. After release: phase 0 and a 69-cycle duration, even though phase 0 had been reprogrammed.
